// File: rtl/trace_pkg.sv
// trace_pkg: shared trace entry layout, entry types and checker FSM state codes.
package trace_pkg;

    localparam int ENTRY_W = 73;

    typedef enum logic [1:0] {
        T_END   = 2'b00,
        T_REG   = 2'b01,
        T_STORE = 2'b10,
        T_SKIP  = 2'b11
    } entry_type_e;

    typedef struct packed {
        entry_type_e typ;
        logic [4:0]  num;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] data;
    } trace_entry_t;

    localparam logic [1:0] S_FETCH = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;
    localparam logic [1:0] S_FAIL  = 2'd3;

endpackage

// File: rtl/wb_trace_checker_if.sv
// wb_trace_checker_if: core debug writeback and data sram-like port as seen by the trace checker.
interface wb_trace_checker_if;
    logic [3:0]  debug_wb_rf_wen;
    logic [4:0]  debug_wb_rf_wnum;
    logic [31:0] debug_wb_rf_wdata;
    logic        data_req;
    logic        data_wr;
    logic        data_addr_ok;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;

    modport master (
        output debug_wb_rf_wen, debug_wb_rf_wnum, debug_wb_rf_wdata,
        output data_req, data_wr, data_addr_ok, data_size, data_addr, data_wdata
    );

    modport slave (
        input debug_wb_rf_wen, debug_wb_rf_wnum, debug_wb_rf_wdata,
        input data_req, data_wr, data_addr_ok, data_size, data_addr, data_wdata
    );
endinterface

// File: rtl/trace_event_fifo.sv
// trace_event_fifo: event queue accepting up to two pushes and one pop per cycle, sticky overflow.
module trace_event_fifo
    import trace_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push0,
    input  trace_entry_t d0,
    input  logic         push1,
    input  trace_entry_t d1,
    input  logic         pop,
    output trace_entry_t head,
    output logic         empty,
    output logic         overflow
);
    localparam int AW = $clog2(DEPTH);

    trace_entry_t mem [DEPTH];
    trace_entry_t first;
    logic [AW-1:0] rp, wp;
    logic [AW:0] cnt, room;
    logic full, any, two, acc0, acc1, ovf;

    // A lone push1 is compacted into the first free slot so order is preserved.
    always_comb begin
        full  = cnt == (AW+1)'(DEPTH);
        room  = (AW+1)'(DEPTH) - cnt + (AW+1)'(pop);
        any   = push0 | push1;
        two   = push0 & push1;
        first = push0 ? d0 : d1;
        acc0  = any && room != '0;
        acc1  = two && room > (AW+1)'(1);
        ovf   = (any && !acc0) || (two && !acc1);
    end

    assign empty = cnt == '0;
    assign head  = mem[rp];

    always_ff @(posedge clk) begin
        if (acc0) mem[wp] <= first;
        if (acc1) mem[wp + 1'b1] <= d1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rp       <= '0;
            wp       <= '0;
            cnt      <= '0;
            overflow <= 1'b0;
        end else begin
            rp       <= rp + AW'(pop);
            wp       <= wp + AW'(acc0) + AW'(acc1);
            cnt      <= cnt + (AW+1)'(acc0) + (AW+1)'(acc1) - (AW+1)'(pop);
            overflow <= overflow | ovf | (full & any & ~pop);
        end
    end
endmodule

// File: rtl/wb_trace_checker.sv
// wb_trace_checker: compares committed register writes and stores in order against a trace ROM.
// Define TRACE_STOP_ON_ERROR_EN to stop at the first mismatch; otherwise mismatch_cnt is exposed.
module wb_trace_checker
    import trace_pkg::*;
#(
    parameter int EVQ_DEPTH = 4,
    parameter int TRACE_AW  = 12,
    parameter int LINE_W    = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    wb_trace_checker_if.slave    bus,
    output logic [TRACE_AW-1:0]  trace_addr,
    input  logic [ENTRY_W-1:0]   trace_rdata,
    output logic                 done,
    output logic                 pass,
    output logic                 fail,
    output logic                 overflow,
    output logic [LINE_W-1:0]    err_line,
    output logic [ENTRY_W-1:0]   err_event,
    output logic [LINE_W-1:0]    line_cnt
`ifndef TRACE_STOP_ON_ERROR_EN
    ,
    output logic [LINE_W-1:0]    mismatch_cnt
`endif
);
    logic [1:0] state;
    trace_entry_t cur, head, ev_reg, ev_st;
    logic live, push_r, push_s, empty, is_end, pop, match;

    assign live   = state == S_FETCH || state == S_RUN;
    assign push_r = live && |bus.debug_wb_rf_wen && bus.debug_wb_rf_wnum != 5'd0;
    assign push_s = live && bus.data_req && bus.data_wr && bus.data_addr_ok;
    assign ev_reg = '{typ: T_REG, num: bus.debug_wb_rf_wnum, size: 2'd0, addr: 32'd0,
                      data: bus.debug_wb_rf_wdata};
    assign ev_st  = '{typ: T_STORE, num: 5'd0, size: bus.data_size, addr: bus.data_addr,
                      data: bus.data_wdata};

    trace_event_fifo #(.DEPTH(EVQ_DEPTH)) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push0    (push_r),
        .d0       (ev_reg),
        .push1    (push_s),
        .d1       (ev_st),
        .pop      (pop),
        .head     (head),
        .empty    (empty),
        .overflow (overflow)
    );

    // In RUN trace_addr is index+1, so it wraps to zero exactly when the index hits the last entry.
    assign is_end = cur.typ == T_END || trace_addr == '0;
    assign pop    = state == S_RUN && !overflow && !is_end && !empty;
    assign match  = cur.typ == T_SKIP
                 || (cur.typ == T_REG && head.typ == T_REG && head.num == cur.num && head.data == cur.data)
                 || (cur.typ == T_STORE && head.typ == T_STORE && head.size == cur.size
                     && head.addr == cur.addr && head.data == cur.data);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_FETCH;
            trace_addr <= '0;
            cur        <= '0;
            done       <= 1'b0;
            pass       <= 1'b0;
            fail       <= 1'b0;
            err_line   <= '0;
            err_event  <= '0;
            line_cnt   <= '0;
`ifndef TRACE_STOP_ON_ERROR_EN
            mismatch_cnt <= '0;
`endif
        end else if (state == S_FETCH) begin
            cur        <= trace_entry_t'(trace_rdata);
            trace_addr <= TRACE_AW'(1);
            state      <= S_RUN;
        end else if (state == S_RUN) begin
            if (overflow) begin
                state <= S_FAIL;
                done  <= 1'b1;
                fail  <= 1'b1;
            end else if (is_end) begin
                state <= S_DONE;
                done  <= 1'b1;
                pass  <= ~fail;
            end else if (pop) begin
                cur        <= trace_entry_t'(trace_rdata);
                trace_addr <= trace_addr + 1'b1;
                line_cnt   <= line_cnt + 1'b1;
                if (!match) begin
                    if (!fail) begin
                        err_line  <= line_cnt + 1'b1;
                        err_event <= head;
                    end
                    fail <= 1'b1;
`ifdef TRACE_STOP_ON_ERROR_EN
                    state <= S_FAIL;
                    done  <= 1'b1;
`else
                    mismatch_cnt <= mismatch_cnt + 1'b1;
`endif
                end
            end
        end
    end
endmodule

// File: tb/tb_wb_trace_checker.sv
// tb_wb_trace_checker: directed scenarios against a combinational trace ROM model.
module tb_wb_trace_checker;
    import trace_pkg::*;

    localparam int AW = 12;
    localparam int LW = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    wb_trace_checker_if bus();

    logic [AW-1:0] trace_addr;
    logic [72:0]   trace_rdata;
    logic          done, pass, fail, overflow;
    logic [LW-1:0] err_line, line_cnt;
    logic [72:0]   err_event;
`ifndef TRACE_STOP_ON_ERROR_EN
    logic [LW-1:0] mismatch_cnt;
`endif

    logic [72:0] rom [4096];
    assign trace_rdata = rom[trace_addr];

    int total = 0;
    int bad = 0;

    wb_trace_checker #(.EVQ_DEPTH(4), .TRACE_AW(AW), .LINE_W(LW)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .trace_addr  (trace_addr),
        .trace_rdata (trace_rdata),
        .done        (done),
        .pass        (pass),
        .fail        (fail),
        .overflow    (overflow),
        .err_line    (err_line),
        .err_event   (err_event),
        .line_cnt    (line_cnt)
`ifndef TRACE_STOP_ON_ERROR_EN
        ,
        .mismatch_cnt(mismatch_cnt)
`endif
    );

    function automatic logic [72:0] e_reg(input logic [4:0] n, input logic [31:0] d);
        return {2'b01, n, 2'b00, 32'h0, d};
    endfunction

    function automatic logic [72:0] e_st(input logic [1:0] s, input logic [31:0] a, input logic [31:0] d);
        return {2'b10, 5'd0, s, a, d};
    endfunction

    localparam logic [72:0] E_SKIP = {2'b11, 71'd0};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_ev();
        bus.debug_wb_rf_wen   = 4'h0;
        bus.debug_wb_rf_wnum  = 5'd0;
        bus.debug_wb_rf_wdata = 32'h0;
        bus.data_req          = 1'b0;
        bus.data_wr           = 1'b0;
        bus.data_addr_ok      = 1'b0;
        bus.data_size         = 2'd0;
        bus.data_addr         = 32'h0;
        bus.data_wdata        = 32'h0;
    endtask

    task automatic drive_reg(input logic [4:0] n, input logic [31:0] d);
        bus.debug_wb_rf_wen   = 4'hf;
        bus.debug_wb_rf_wnum  = n;
        bus.debug_wb_rf_wdata = d;
    endtask

    task automatic drive_st(input logic [1:0] s, input logic [31:0] a, input logic [31:0] d);
        bus.data_req     = 1'b1;
        bus.data_wr      = 1'b1;
        bus.data_addr_ok = 1'b1;
        bus.data_size    = s;
        bus.data_addr    = a;
        bus.data_wdata   = d;
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 4096; i++) rom[i] = '0;
    endtask

    task automatic do_reset();
        clear_ev();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic wait_done(input int n);
        for (int i = 0; i < n && done !== 1'b1; i++) step();
        total++; if (done !== 1'b1) begin bad++; $display("FAIL wait_done timeout done=%b want 1", done); end
    endtask

    task automatic test_reset();
        clear_rom();
        clear_ev();
        rst = 1'b1;
        step();
        step();
        total++; if (trace_addr !== 12'd0) begin bad++; $display("FAIL rst trace_addr got %0d want 0", trace_addr); end
        total++; if ({done, pass, fail, overflow} !== 4'b0) begin bad++; $display("FAIL rst flags got %b want 0000", {done, pass, fail, overflow}); end
        total++; if (err_line !== 16'd0 || line_cnt !== 16'd0) begin bad++; $display("FAIL rst counters err_line=%0d line_cnt=%0d want 0", err_line, line_cnt); end
        total++; if (err_event !== 73'd0) begin bad++; $display("FAIL rst err_event got %h want 0", err_event); end
        rst = 1'b0;
        step();
        total++; if (trace_addr !== 12'd1 || done !== 1'b0) begin bad++; $display("FAIL fetch trace_addr=%0d done=%b want 1,0", trace_addr, done); end
        wait_done(4);
        total++; if (pass !== 1'b1 || line_cnt !== 16'd0) begin bad++; $display("FAIL empty_trace pass=%b line_cnt=%0d want 1,0", pass, line_cnt); end
    endtask

    task automatic test_reg_match();
        clear_rom();
        rom[0] = e_reg(5'd1, 32'h0000_1234);
        do_reset();
        drive_reg(5'd1, 32'h0000_1234);
        step();
        clear_ev();
        wait_done(4);
        total++; if (line_cnt !== 16'd1) begin bad++; $display("FAIL reg_match line_cnt got %0d want 1", line_cnt); end
        total++; if (pass !== 1'b1 || fail !== 1'b0) begin bad++; $display("FAIL reg_match pass=%b fail=%b want 1,0", pass, fail); end
    endtask

    task automatic test_reg_mismatch();
        clear_rom();
        rom[0] = e_reg(5'd1, 32'h0000_1234);
        do_reset();
        drive_reg(5'd1, 32'h0000_1235);
        step();
        clear_ev();
        wait_done(4);
        total++; if (fail !== 1'b1 || pass !== 1'b0) begin bad++; $display("FAIL reg_mismatch fail=%b pass=%b want 1,0", fail, pass); end
        total++; if (err_line !== 16'd1) begin bad++; $display("FAIL reg_mismatch err_line got %0d want 1", err_line); end
        total++; if (err_event !== e_reg(5'd1, 32'h0000_1235)) begin bad++; $display("FAIL reg_mismatch err_event got %h want %h", err_event, e_reg(5'd1, 32'h0000_1235)); end
`ifndef TRACE_STOP_ON_ERROR_EN
        total++; if (mismatch_cnt !== 16'd1) begin bad++; $display("FAIL reg_mismatch mismatch_cnt got %0d want 1", mismatch_cnt); end
`endif
    endtask

    task automatic test_dual();
        clear_rom();
        rom[0] = e_reg(5'd2, 32'hdead_beef);
        rom[1] = e_st(2'd2, 32'h80, 32'h1122_3344);
        do_reset();
        drive_reg(5'd2, 32'hdead_beef);
        drive_st(2'd2, 32'h80, 32'h1122_3344);
        step();
        clear_ev();
        wait_done(6);
        total++; if (pass !== 1'b1 || fail !== 1'b0) begin bad++; $display("FAIL dual pass=%b fail=%b want 1,0", pass, fail); end
        total++; if (line_cnt !== 16'd2) begin bad++; $display("FAIL dual line_cnt got %0d want 2", line_cnt); end
    endtask

    task automatic test_skip();
        clear_rom();
        rom[0] = E_SKIP;
        do_reset();
        drive_st(2'd0, 32'h10, 32'hff);
        step();
        clear_ev();
        wait_done(4);
        total++; if (pass !== 1'b1 || line_cnt !== 16'd1) begin bad++; $display("FAIL skip pass=%b line_cnt=%0d want 1,1", pass, line_cnt); end
    endtask

    task automatic test_back_to_back();
        clear_rom();
        for (int i = 0; i < 6; i++) rom[i] = e_reg(5'(i + 1), 32'(i * 3 + 7));
        do_reset();
        for (int i = 0; i < 6; i++) begin
            drive_reg(5'(i + 1), 32'(i * 3 + 7));
            step();
        end
        clear_ev();
        wait_done(6);
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL b2b overflow got %b want 0", overflow); end
        total++; if (pass !== 1'b1 || line_cnt !== 16'd6) begin bad++; $display("FAIL b2b pass=%b line_cnt=%0d want 1,6", pass, line_cnt); end
    endtask

    task automatic test_overflow();
        clear_rom();
        for (int i = 0; i < 20; i++) rom[i] = E_SKIP;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            drive_reg(5'd3, 32'(i));
            drive_st(2'd2, 32'(i * 4), 32'(i));
            step();
        end
        clear_ev();
        wait_done(4);
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL overflow flag got %b want 1", overflow); end
        total++; if (fail !== 1'b1 || pass !== 1'b0) begin bad++; $display("FAIL overflow fail=%b pass=%b want 1,0", fail, pass); end
    endtask

    task automatic test_mid_reset();
        clear_rom();
        for (int i = 0; i < 6; i++) rom[i] = e_reg(5'(i + 1), 32'(i * 3 + 7));
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive_reg(5'(i + 1), 32'(i * 3 + 7));
            step();
        end
        clear_ev();
        step();
        step();
        total++; if (line_cnt !== 16'd3) begin bad++; $display("FAIL mid_reset pre line_cnt got %0d want 3", line_cnt); end
        rst = 1'b1;
        step();
        total++; if (line_cnt !== 16'd0 || trace_addr !== 12'd0 || done !== 1'b0) begin bad++; $display("FAIL mid_reset rst line_cnt=%0d trace_addr=%0d done=%b want 0,0,0", line_cnt, trace_addr, done); end
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            drive_reg(5'(i + 1), 32'(i * 3 + 7));
            step();
        end
        clear_ev();
        wait_done(6);
        total++; if (pass !== 1'b1 || line_cnt !== 16'd6) begin bad++; $display("FAIL mid_reset replay pass=%b line_cnt=%0d want 1,6", pass, line_cnt); end
    endtask

    task automatic test_index_limit();
        for (int i = 0; i < 4096; i++) rom[i] = E_SKIP;
        do_reset();
        for (int i = 0; i < 4100; i++) begin
            drive_reg(5'd4, 32'(i));
            step();
        end
        clear_ev();
        wait_done(8);
        total++; if (line_cnt !== 16'd4095) begin bad++; $display("FAIL index_limit line_cnt got %0d want 4095", line_cnt); end
        total++; if (pass !== 1'b1 || overflow !== 1'b0) begin bad++; $display("FAIL index_limit pass=%b overflow=%b want 1,0", pass, overflow); end
    endtask

    initial begin
        test_reset();
        test_reg_match();
        test_reg_mismatch();
        test_dual();
        test_skip();
        test_back_to_back();
        test_overflow();
        test_mid_reset();
        test_index_limit();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/wb_trace_checker.md
Name: wb_trace_checker

Overview:
- Synthesizable commit-trace checker that sits directly downstream of the mips core's debug writeback port and data sram-like port.
- Captures register-write and store events, compares them in order against an expected trace held in an external ROM, and reports pass/fail with the first failing line.
- Replaces the behavioural compare loop so FPGA runs and simulation check traces the same way.

Parameters:
- EVQ_DEPTH, 4, event FIFO depth (power of two, ≥2)
- TRACE_AW, 12, trace ROM address width (max 4096 entries)
- LINE_W, 16, width of line and mismatch counters

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- debug_wb_rf_wen  in  4  core writeback enable; any bit set means a write
- debug_wb_rf_wnum  in  5  writeback register number
- debug_wb_rf_wdata  in  32  writeback data
- data_req  in  1  data sram-like request
- data_wr  in  1  data request is a write
- data_addr_ok  in  1  data address handshake
- data_size  in  2  store size code (0/1/2 → 1/2/4 bytes)
- data_addr  in  32  store address
- data_wdata  in  32  store data
- trace_addr  out  TRACE_AW  trace ROM read index
- trace_rdata  in  73  entry {type[72:71], num[70:66], size[65:64], addr[63:32], data[31:0]}; valid one cycle after trace_addr
- done  out  1  end-of-trace reached
- pass  out  1  done with zero mismatches and no overflow
- fail  out  1  mismatch or overflow detected
- overflow  out  1  event FIFO overflowed
- err_line  out  LINE_W  1-based line of first mismatch
- err_event  out  73  captured event at first mismatch (same layout)
- line_cnt  out  LINE_W  events checked so far

Behaviour:
- Event capture (combinational qualify, registered push):
  - reg event when wen≠0 and wnum≠0
  - store event when data_req & data_wr & data_addr_ok
  - Both in one cycle: push reg first, then store (2 pushes).
- Entry types: 00 END, 01 REG (compare num, data), 10 STORE (compare size, addr, data), 11 SKIP (matches any event).
- FSM states:
  - FETCH: one cycle after reset; issues trace_addr=0.
  - RUN: holds the current entry register. trace_addr is always the current index +1, so the next entry is prefetched and throughput is 1 compare/cycle.
  - DONE: terminal.
  - FAIL: terminal.
- RUN, FIFO non-empty and entry ≠ END:
  - Pop one event, compare, increment line_cnt.
  - Advance entry from the prefetch register and issue the next address, same cycle.
- Mismatch:
  - On the first mismatch only, latch err_line=line_cnt+1 and err_event.
  - Then go to FAIL (with macro) or continue (without).
- RUN, entry = END: go to DONE. Events still queued or arriving later are ignored.
- Overflow: a push into a full FIFO sets overflow, drops the event and forces FAIL. A push and pop in the same cycle on a full FIFO is not overflow.
- Trace index reaching 2^TRACE_AW−1 without END: treated as END.
- Output reset values:
  - done, pass, fail, overflow = 0
  - err_line, err_event, line_cnt = 0
  - trace_addr = 0
  - FIFO empty, state FETCH
- Output derivation:
  - pass = done & ~fail
  - done asserts in DONE or FAIL
  - All outputs are registered.
- Reset mid-run: everything returns to reset values next cycle; the trace restarts at index 0.

Optional Feature:
- TRACE_STOP_ON_ERROR_EN
  - Defined: the first mismatch enters FAIL immediately; further events are ignored.
  - Undefined: checking continues to END; fail is sticky; an extra output mismatch_cnt[LINE_W] counts all mismatches. Port is present only when undefined.

Decomposition:
- trace_pkg:
  - entry-type enum (END/REG/STORE/SKIP)
  - packed struct trace_entry_t (73 bits)
  - ENTRY_W=73
  - state enum
- Sub-module trace_event_fifo:
  - parameterised depth, 2-push/1-pop
  - full/empty/overflow flags
  - synchronous clear on rst

Test Plan:
- Trace {REG $1=0x00001234, END}; core writes $1=0x00001234 → line_cnt=1, done=1, pass=1, fail=0 within 4 cycles of the event.
- Same trace; core writes $1=0x00001235 → fail=1, err_line=1, err_event.data=0x00001235, pass=0.
- Simultaneous reg write $2=0xdeadbeef and store [0x80,4]=0x11223344; trace {REG, STORE, END} → both match in order, pass=1.
- SKIP entry against store [0x10,1]=0xff → counted as match; line_cnt increments.
- Six events on six consecutive cycles with EVQ_DEPTH=4 and a matching trace → no overflow (1/cycle drain). Forced 2-push burst on a full FIFO → overflow=1, fail=1.
- rst asserted mid-trace after 3 events, then the full trace replayed → line_cnt restarts at 0, final pass=1.
